seg_scanner: RTL and testbench
==============================

# seg_scanner

Time-multiplexed driver for an NumDigits-wide common-anode seven-segment display. It consumes the slow square-wave `Refresh` strobe produced by the refresh-rate generator and advances one digit on every `Refresh` transition. It drives one-hot anode and segment outputs from a frame-synchronous, double-buffered copy of the value to be shown. It sits between the refresh generator and the board display pins.

## Interface
- `NumDigits`, 4: number of digits scanned, 2..8.
- `ActiveLowAn`, 1: 1 drives anodes active-low; 0 drives them active-high.
- `ActiveLowSeg`, 1: 1 drives segments and DP active-low; 0 drives them active-high.

Ports (reset `Rst`, synchronous, active-high; clock `Clk`):
- `Clk`  in  1  system clock.
- `Rst`  in  1  synchronous active-high reset.
- `Refresh`  in  1  refresh square wave; each transition is one digit step.
- `Load`  in  1  one-cycle request to capture `Value`/`DpMask`.
- `Value`  in  4*NumDigits  hex nibbles; nibble i is digit i, digit 0 is rightmost.
- `DpMask`  in  NumDigits  decimal point enable per digit.
- `Blank`  in  1  level; forces all anodes inactive.
- `Anode`  out  NumDigits  one-hot digit enable (polarity per `ActiveLowAn`).
- `Seg`  out  7  segments {g,f,e,d,c,b,a}, bit 6..0.
- `Dp`  out  1  decimal point.
- `Pending`  out  1  the shadow register holds data not yet displayed.
- `FrameStart`  out  1  one-cycle pulse when digit 0 becomes the active digit.

## Operation
- `RefPrev` is registered every cycle. `Step = Refresh ^ RefPrev`. Both edges of `Refresh` count as steps.
- Digit index `Idx` runs 0..NumDigits-1 and wraps to 0 on `Step`. A step from NumDigits-1 to 0 is a frame boundary.
- `Active` flag:
  - Cleared by reset; set on the first `Step`.
  - While `Active` is 0, all outputs hold their inactive levels.
- Load and commit:
  - `Load` writes `Value`/`DpMask` into shadow registers and sets `Pending`.
  - At a frame boundary the shadow is copied into the display registers and `Pending` clears.
  - A later `Load` before the boundary overwrites the shadow; the last one wins.
  - `Load` in the same cycle as a frame-boundary step writes the input directly into both shadow and display registers. `Pending` stays 0.
- Output path, registered:
  - `Anode` is one-hot at `Idx`.
  - `Seg` is the hex decode of display nibble `Idx`.
  - `Dp` is `DpMask[Idx]`.
- Hex decode, active-high internal form: 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F, A=0x77, b=0x7C, C=0x39, d=0x5E, E=0x79, F=0x71. Inverted when `ActiveLowSeg`=1.
- `Blank`=1 drives `Anode` inactive. `Idx`, `Pending` and `FrameStart` continue normally.
- Reset values: `Anode` all inactive, `Seg` and `Dp` off at their configured polarity, `Pending`=0, `FrameStart`=0, `Idx`=0, shadow and display registers 0, `RefPrev`=0.
- Reset mid-frame blanks the display immediately at the next edge. A pending shadow value is discarded.

## Timing
- Suppose `Refresh` changes between edge k-1 and edge k. At edge k, `Idx` advances and `RefPrev` updates. At edge k+1, `Anode`/`Seg`/`Dp` reflect the new digit. Latency is 2 edges.
- `FrameStart` is high for exactly the cycle after edge k+1 of a frame-boundary step, aligned with the first cycle in which digit 0 is shown.
- A display commit at edge k is visible on `Seg` from edge k+1.
- `Pending` falls at edge k.
- `Blank` and polarity take effect 1 edge after sampling.
- `Refresh` must be stable for at least 2 `Clk` cycles between transitions. Faster toggling is out of spec.

## Configuration
- `SEG_LZB_EN` defined: leading-zero blanking.
  - A digit is blanked (`Seg` off; `Anode` still active) if its nibble and every higher nibble are 0 and no `DpMask` bit at that or higher position is set.
  - Digit 0 is never blanked.
- `SEG_LZB_EN` undefined: every digit is always decoded; zeros show as 0x3F.

## Structure
- Package `seg_pkg` holds:
  - the 16 segment-encoding constants,
  - a `SEG_OFF` constant,
  - a hex-to-seg function,
  - the digit-width localparam helper.
- Sub-module `seg_hex_decoder`: purely combinational nibble-to-7-segment decode, instantiated once on the muxed nibble.

## Test plan
- Reset, then no `Refresh` activity for 100 cycles -> `Anode`=4'b1111, `Seg`=7'h7F, `Dp`=1, `Pending`=0.
- `Load` `Value`=16'h1234, then 4 `Refresh` transitions -> digits 0..3 show 0x19/0x30/0x24/0x79 (active-low 4,3,2,1). `Anode` sequence 1110, 1101, 1011, 0111. Each change occurs 2 edges after the `Refresh` change.
- `Load` 16'hABCD while at digit 2 -> `Pending`=1 until the wrap to 0. Digit 3 still shows the old value. After the wrap, digit 0 shows 'd' (0x21). `FrameStart` pulses once.
- `Load` coincident with a frame-boundary step -> new value shown on digit 0 at the next edge, `Pending` never rises.
- `SEG_LZB_EN` with `Value`=16'h0050 -> digits 3,2 show `Seg`=7'h7F with `Anode` active; digit 1 shows 5; digit 0 shows 0. With `DpMask`=4'b1000, digits 3,2 show 0.
- `Rst` asserted mid-frame with `Pending`=1 -> all outputs inactive next edge. After release, the first step shows digit 1 with value 0.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment scanner: segment encodings,
// the blank pattern, the nibble decode function and the index-width helper.
package seg_pkg;

    // Segment patterns in active-high form, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_HEX_0 = 7'h3F;
    localparam logic [6:0] SEG_HEX_1 = 7'h06;
    localparam logic [6:0] SEG_HEX_2 = 7'h5B;
    localparam logic [6:0] SEG_HEX_3 = 7'h4F;
    localparam logic [6:0] SEG_HEX_4 = 7'h66;
    localparam logic [6:0] SEG_HEX_5 = 7'h6D;
    localparam logic [6:0] SEG_HEX_6 = 7'h7D;
    localparam logic [6:0] SEG_HEX_7 = 7'h07;
    localparam logic [6:0] SEG_HEX_8 = 7'h7F;
    localparam logic [6:0] SEG_HEX_9 = 7'h6F;
    localparam logic [6:0] SEG_HEX_A = 7'h77;
    localparam logic [6:0] SEG_HEX_B = 7'h7C;
    localparam logic [6:0] SEG_HEX_C = 7'h39;
    localparam logic [6:0] SEG_HEX_D = 7'h5E;
    localparam logic [6:0] SEG_HEX_E = 7'h79;
    localparam logic [6:0] SEG_HEX_F = 7'h71;

    // All segments dark, active-high form
    localparam logic [6:0] SEG_OFF = 7'h00;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } scan_state_e;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        seg = SEG_OFF;
        case (nib)
            4'h0: seg = SEG_HEX_0;
            4'h1: seg = SEG_HEX_1;
            4'h2: seg = SEG_HEX_2;
            4'h3: seg = SEG_HEX_3;
            4'h4: seg = SEG_HEX_4;
            4'h5: seg = SEG_HEX_5;
            4'h6: seg = SEG_HEX_6;
            4'h7: seg = SEG_HEX_7;
            4'h8: seg = SEG_HEX_8;
            4'h9: seg = SEG_HEX_9;
            4'hA: seg = SEG_HEX_A;
            4'hB: seg = SEG_HEX_B;
            4'hC: seg = SEG_HEX_C;
            4'hD: seg = SEG_HEX_D;
            4'hE: seg = SEG_HEX_E;
            4'hF: seg = SEG_HEX_F;
            default: seg = SEG_OFF;
        endcase
        return seg;
    endfunction

    // Width of a digit index for a display of n digits (at least one bit)
    function automatic int digit_idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/seg_hex_decoder.sv
// Combinational nibble to seven-segment decode, active-high output.
module seg_hex_decoder
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg_raw
);

    // Table lookup through the shared decode function
    always_comb begin
        seg_raw = hex_to_seg(nibble);
    end

endmodule

// File: rtl/seg_scanner.sv
// Time-multiplexed common-anode seven-segment driver. One digit step per
// Refresh transition; value/DP mask double-buffered and committed at the
// frame boundary. Optional build macro SEG_LZB_EN enables leading-zero
// blanking (digit 0 is never blanked).
//
// state   | meaning
// --------+------------------------------------------------------
// ST_IDLE | no Refresh step seen since reset; outputs held inactive
// ST_SCAN | scanning digits; outputs follow the current index
module seg_scanner
    import seg_pkg::*;
#(
    parameter int NumDigits    = 4,
    parameter bit ActiveLowAn  = 1'b1,
    parameter bit ActiveLowSeg = 1'b1
) (
    input  logic                   Clk,
    input  logic                   Rst,
    input  logic                   Refresh,
    input  logic                   Load,
    input  logic [4*NumDigits-1:0] Value,
    input  logic [NumDigits-1:0]   DpMask,
    input  logic                   Blank,
    output logic [NumDigits-1:0]   Anode,
    output logic [6:0]             Seg,
    output logic                   Dp,
    output logic                   Pending,
    output logic                   FrameStart
);

    localparam int                  IdxW    = digit_idx_w(NumDigits);
    localparam logic [IdxW-1:0]     IdxLast = IdxW'(NumDigits - 1);
    localparam logic [NumDigits-1:0] AnInv  = {NumDigits{ActiveLowAn}};
    localparam logic [6:0]          SegInv  = {7{ActiveLowSeg}};

    scan_state_e st_q, st_d;

    logic                   ref_prev_q, ref_prev_d;
    logic [IdxW-1:0]        idx_q, idx_d;
    logic [4*NumDigits-1:0] shadow_val_q, shadow_val_d;
    logic [NumDigits-1:0]   shadow_dp_q, shadow_dp_d;
    logic [4*NumDigits-1:0] disp_val_q, disp_val_d;
    logic [NumDigits-1:0]   disp_dp_q, disp_dp_d;
    logic                   pending_q, pending_d;
    logic                   wrap_q, wrap_d;
    logic                   frame_start_q, frame_start_d;
    logic [NumDigits-1:0]   anode_q, anode_d;
    logic [6:0]             seg_q, seg_d;
    logic                   dp_q, dp_d;

    logic                   step;
    logic                   boundary;
    logic [3:0]             nibble;
    logic [6:0]             dec_seg;
    logic [NumDigits-1:0]   onehot;
    logic                   dp_sel;
    logic [NumDigits-1:0]   lz_blank;

    // Scan state register
    always_ff @(posedge Clk) begin
        if (Rst) begin
            st_q <= ST_IDLE;
        end else begin
            st_q <= st_d;
        end
    end

    // Leave idle on the first Refresh step and keep scanning until reset
    always_comb begin
        st_d = st_q;
        case (st_q)
            ST_IDLE: if (step) st_d = ST_SCAN;
            ST_SCAN: st_d = ST_SCAN;
            default: st_d = ST_IDLE;
        endcase
    end

    // Edge detect, digit index, double buffer and frame-boundary tracking
    always_comb begin
        ref_prev_d   = Refresh;
        step         = Refresh ^ ref_prev_q;
        boundary     = step && (idx_q == IdxLast);
        idx_d        = idx_q;
        shadow_val_d = shadow_val_q;
        shadow_dp_d  = shadow_dp_q;
        disp_val_d   = disp_val_q;
        disp_dp_d    = disp_dp_q;
        pending_d    = pending_q;

        if (step) begin
            idx_d = boundary ? '0 : idx_q + IdxW'(1);
        end

        if (Load) begin
            shadow_val_d = Value;
            shadow_dp_d  = DpMask;
        end

        // A load coinciding with the boundary bypasses the shadow so it
        // never shows up as pending
        if (boundary) begin
            pending_d = 1'b0;
            if (Load) begin
                disp_val_d = Value;
                disp_dp_d  = DpMask;
            end else begin
                disp_val_d = shadow_val_q;
                disp_dp_d  = shadow_dp_q;
            end
        end else if (Load) begin
            pending_d = 1'b1;
        end

        // Delay the boundary one cycle so FrameStart lines up with digit 0
        // appearing on the registered outputs
        wrap_d        = boundary;
        frame_start_d = wrap_q;
    end

    // Datapath registers
    always_ff @(posedge Clk) begin
        if (Rst) begin
            ref_prev_q    <= 1'b0;
            idx_q         <= '0;
            shadow_val_q  <= '0;
            shadow_dp_q   <= '0;
            disp_val_q    <= '0;
            disp_dp_q     <= '0;
            pending_q     <= 1'b0;
            wrap_q        <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            ref_prev_q    <= ref_prev_d;
            idx_q         <= idx_d;
            shadow_val_q  <= shadow_val_d;
            shadow_dp_q   <= shadow_dp_d;
            disp_val_q    <= disp_val_d;
            disp_dp_q     <= disp_dp_d;
            pending_q     <= pending_d;
            wrap_q        <= wrap_d;
            frame_start_q <= frame_start_d;
        end
    end

    // Select the current digit's nibble, DP bit and anode
    always_comb begin
        nibble = 4'h0;
        dp_sel = 1'b0;
        onehot = '0;
        for (int i = 0; i < NumDigits; i++) begin
            if (idx_q == IdxW'(i)) begin
                nibble    = disp_val_q[4*i +: 4];
                dp_sel    = disp_dp_q[i];
                onehot[i] = 1'b1;
            end
        end
    end

`ifdef SEG_LZB_EN
    // A digit is a leading zero if it and everything above it is zero with
    // no decimal point lit at or above it; digit 0 always shows
    always_comb begin
        logic zero_above;
        zero_above = 1'b1;
        lz_blank   = '0;
        for (int i = NumDigits - 1; i >= 1; i--) begin
            zero_above  = zero_above && (disp_val_q[4*i +: 4] == 4'h0) && !disp_dp_q[i];
            lz_blank[i] = zero_above;
        end
    end
`else
    // Every digit is decoded
    always_comb begin
        lz_blank = '0;
    end
`endif

    seg_hex_decoder u_dec (
        .nibble  (nibble),
        .seg_raw (dec_seg)
    );

    // Output stage next values: inactive while idle, polarity applied last
    always_comb begin
        logic [NumDigits-1:0] an_int;
        logic [6:0]           seg_int;
        logic                 dp_int;
        an_int  = '0;
        seg_int = SEG_OFF;
        dp_int  = 1'b0;
        if (st_q == ST_SCAN) begin
            an_int  = Blank ? '0 : onehot;
            seg_int = (|(lz_blank & onehot)) ? SEG_OFF : dec_seg;
            dp_int  = dp_sel;
        end
        anode_d = an_int ^ AnInv;
        seg_d   = seg_int ^ SegInv;
        dp_d    = dp_int ^ ActiveLowSeg;
    end

    // Output registers
    always_ff @(posedge Clk) begin
        if (Rst) begin
            anode_q <= AnInv;
            seg_q   <= SEG_OFF ^ SegInv;
            dp_q    <= ActiveLowSeg;
        end else begin
            anode_q <= anode_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
        end
    end

    assign Anode      = anode_q;
    assign Seg        = seg_q;
    assign Dp         = dp_q;
    assign Pending    = pending_q;
    assign FrameStart = frame_start_q;

endmodule

// File: tb/tb_seg_scanner.sv
// Directed bench for seg_scanner (4 digits, active-low anodes and segments).
module tb_seg_scanner;

    logic        Clk;
    logic        Rst;
    logic        Refresh;
    logic        Load;
    logic [15:0] Value;
    logic [3:0]  DpMask;
    logic        Blank;
    logic [3:0]  Anode;
    logic [6:0]  Seg;
    logic        Dp;
    logic        Pending;
    logic        FrameStart;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef SEG_LZB_EN
    localparam logic [6:0] ZBLK = 7'h7F;
`else
    localparam logic [6:0] ZBLK = 7'h40;
`endif

    seg_scanner #(
        .NumDigits    (4),
        .ActiveLowAn  (1'b1),
        .ActiveLowSeg (1'b1)
    ) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .Refresh    (Refresh),
        .Load       (Load),
        .Value      (Value),
        .DpMask     (DpMask),
        .Blank      (Blank),
        .Anode      (Anode),
        .Seg        (Seg),
        .Dp         (Dp),
        .Pending    (Pending),
        .FrameStart (FrameStart)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [3:0] an, input logic [6:0] sg, input logic dp);
        check({tag, "_an"},  32'(Anode), 32'(an));
        check({tag, "_seg"}, 32'(Seg),   32'(sg));
        check({tag, "_dp"},  32'(Dp),    32'(dp));
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Toggle Refresh, then return one step after the outputs have updated
    task automatic do_step();
        Refresh = ~Refresh;
        tick();
        tick();
    endtask

    task automatic load(input logic [15:0] v, input logic [3:0] m);
        Load   = 1'b1;
        Value  = v;
        DpMask = m;
        tick();
        Load   = 1'b0;
    endtask

    initial begin
        Rst = 1'b1; Refresh = 1'b0; Load = 1'b0; Value = '0; DpMask = '0; Blank = 1'b0;
        repeat (3) @(posedge Clk);
        #1 Rst = 1'b0;

        // Idle after reset with no Refresh activity
        repeat (100) tick();
        chk_out("idle", 4'hF, 7'h7F, 1'b1);
        check("idle_pend", 32'(Pending), 32'd0);
        check("idle_fs", 32'(FrameStart), 32'd0);

        // First frame: 1234 waits in the shadow until the wrap
        load(16'h1234, 4'h0);
        check("pend_1234", 32'(Pending), 32'd1);
        Refresh = ~Refresh;
        tick();
        check("lat_an", 32'(Anode), 32'hF);
        tick();
        chk_out("s1", 4'b1101, 7'h40, 1'b1);
        do_step(); chk_out("s2", 4'b1011, 7'h40, 1'b1);
        do_step(); chk_out("s3", 4'b0111, 7'h40, 1'b1);
        check("s3_pend", 32'(Pending), 32'd1);
        do_step(); chk_out("f1d0", 4'b1110, 7'h19, 1'b1);
        check("f1_pend", 32'(Pending), 32'd0);
        check("f1_fs", 32'(FrameStart), 32'd1);
        tick();
        check("f1_fs_end", 32'(FrameStart), 32'd0);
        do_step(); chk_out("f1d1", 4'b1101, 7'h30, 1'b1);
        do_step(); chk_out("f1d2", 4'b1011, 7'h24, 1'b1);
        do_step(); chk_out("f1d3", 4'b0111, 7'h79, 1'b1);
        do_step(); chk_out("f2d0", 4'b1110, 7'h19, 1'b1);
        do_step(); chk_out("f2d1", 4'b1101, 7'h30, 1'b1);
        do_step(); chk_out("f2d2", 4'b1011, 7'h24, 1'b1);

        // Load ABCD mid-frame: old value stays until the wrap
        load(16'hABCD, 4'b0001);
        check("abcd_pend", 32'(Pending), 32'd1);
        do_step(); chk_out("f2d3", 4'b0111, 7'h79, 1'b1);
        check("f2d3_pend", 32'(Pending), 32'd1);
        do_step(); chk_out("f3d0", 4'b1110, 7'h21, 1'b0);
        check("f3_pend", 32'(Pending), 32'd0);
        check("f3_fs", 32'(FrameStart), 32'd1);
        tick();
        check("f3_fs_end", 32'(FrameStart), 32'd0);
        do_step(); chk_out("f3d1", 4'b1101, 7'h46, 1'b1);
        do_step(); chk_out("f3d2", 4'b1011, 7'h03, 1'b1);
        do_step(); chk_out("f3d3", 4'b0111, 7'h08, 1'b1);

        // Load coincident with the boundary step goes straight to display
        Refresh = ~Refresh;
        Load    = 1'b1;
        Value   = 16'h5678;
        DpMask  = 4'h0;
        tick();
        Load = 1'b0;
        check("coin_pend_k", 32'(Pending), 32'd0);
        tick();
        chk_out("coin_d0", 4'b1110, 7'h00, 1'b1);
        check("coin_pend", 32'(Pending), 32'd0);
        check("coin_fs", 32'(FrameStart), 32'd1);

        // Blank only kills the anodes
        Blank = 1'b1;
        tick();
        check("blank_an", 32'(Anode), 32'hF);
        check("blank_seg", 32'(Seg), 32'h00);
        Blank = 1'b0;
        tick();
        check("unblank_an", 32'(Anode), 32'hE);

        // Reset mid-frame with a pending value
        do_step(); chk_out("f4d1", 4'b1101, 7'h78, 1'b1);
        load(16'h9999, 4'hF);
        check("rst_pend_pre", 32'(Pending), 32'd1);
        do_step(); chk_out("f4d2", 4'b1011, 7'h02, 1'b1);
        Rst = 1'b1;
        tick();
        chk_out("rst", 4'hF, 7'h7F, 1'b1);
        check("rst_pend", 32'(Pending), 32'd0);
        Rst = 1'b0;
        tick();
        chk_out("rst_idle", 4'hF, 7'h7F, 1'b1);
        do_step(); chk_out("rst_s1", 4'b1101, ZBLK, 1'b1);
        check("rst_s1_pend", 32'(Pending), 32'd0);

        // Leading zeros (blanked only when SEG_LZB_EN is built in)
        load(16'h0050, 4'h0);
        do_step(); chk_out("lz_a2", 4'b1011, ZBLK, 1'b1);
        do_step(); chk_out("lz_a3", 4'b0111, ZBLK, 1'b1);
        do_step(); chk_out("lz_b0", 4'b1110, 7'h40, 1'b1);
        do_step(); chk_out("lz_b1", 4'b1101, 7'h12, 1'b1);
        do_step(); chk_out("lz_b2", 4'b1011, ZBLK, 1'b1);
        do_step(); chk_out("lz_b3", 4'b0111, ZBLK, 1'b1);
        load(16'h0050, 4'b1000);
        do_step(); chk_out("lz_c0", 4'b1110, 7'h40, 1'b1);
        do_step(); chk_out("lz_c1", 4'b1101, 7'h12, 1'b1);
        do_step(); chk_out("lz_c2", 4'b1011, 7'h40, 1'b1);
        do_step(); chk_out("lz_c3", 4'b0111, 7'h40, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
